// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: default geometry, derived field
// widths for the default geometry, and FSM state encodings.
package dcache_pkg;

    localparam int unsigned DEF_SETS       = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;

    localparam int unsigned OFFSET_W = $clog2(DEF_LINE_WORDS);
    localparam int unsigned INDEX_W  = $clog2(DEF_SETS);
    localparam int unsigned TAG_W    = 32 - 2 - OFFSET_W - INDEX_W;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t FILL_REQ  = 2'd1;
    localparam state_t FILL_WAIT = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears valid bits)
//   rd_idx, rd_off        combinational lookup: rd_valid, rd_tag, rd_word
//   wr_en, wr_idx, wr_off synchronous word write of wr_data under wr_be
//   tag_we, tag_idx       write tag_val and set the valid bit of tag_idx
//   clr_all               clear every valid bit; overrides a same-cycle tag_we
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
    localparam int unsigned IDX_W     = $clog2(SETS),
    localparam int unsigned TG_W      = 32 - 2 - OFF_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TG_W-1:0]  rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    input  logic             tag_we,
    input  logic [IDX_W-1:0] tag_idx,
    input  logic [TG_W-1:0]  tag_val,
    input  logic             clr_all
);

    logic [SETS-1:0] valid_q;
    logic [TG_W-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS*LINE_WORDS];

    logic [IDX_W+OFF_W-1:0] rd_a;
    logic [IDX_W+OFF_W-1:0] wr_a;

    assign rd_a     = {rd_idx, rd_off};
    assign wr_a     = {wr_idx, wr_off};
    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_a];

    // Valid bits: invalidate-all beats a completing fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[tag_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; validity is tracked by valid_q.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[tag_idx] <= tag_val;
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_a][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/we/addr/wdata/be   MEM-stage load/store request
//   inv                          invalidate all lines at the next edge
//   rdata, stall                 load data and pipeline freeze (combinational)
//   mem_req_*                    request channel to backing memory (valid/ready)
//   mem_rvalid, mem_rdata        refill beats, ascending word order
// Optional: define DCACHE_STATS_EN to add hit_cnt/miss_cnt load counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic        inv,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req_valid,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_req_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TG_W   = 32 - 2 - OFF_W - IDX_W;
    localparam int unsigned LINE_W = TG_W + IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t           state_q, state_d;
    logic [OFF_W-1:0] beat_q;
    logic [LINE_W-1:0] fill_line_q;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TG_W-1:0]  req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TG_W-1:0]  fill_tag;

    logic             rd_valid;
    logic [TG_W-1:0]  rd_tag;
    logic [31:0]      rd_word;
    logic             hit;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [OFF_W-1:0] wr_off;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;
    logic             tag_we;
    logic             miss_start;
    logic             load_hit;
    logic             unused_addr_lsb;

    assign req_off  = req_addr[2 +: OFF_W];
    assign req_idx  = req_addr[2+OFF_W +: IDX_W];
    assign req_tag  = req_addr[31 -: TG_W];
    assign fill_idx = fill_line_q[IDX_W-1:0];
    assign fill_tag = fill_line_q[LINE_W-1 -: TG_W];
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign unused_addr_lsb = ^req_addr[1:0];

    dcache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_off   (req_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .tag_we   (tag_we),
        .tag_idx  (fill_idx),
        .tag_val  (fill_tag),
        .clr_all  (inv)
    );

    // State, beat counter and latched miss line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            fill_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FILL_WAIT && mem_rvalid) begin
                beat_q <= beat_q + OFF_W'(1);
            end
            if (miss_start) begin
                fill_line_q <= req_addr[31 -: LINE_W];
            end
        end
    end

    // Next state, lookup response, memory request and array write steering.
    always_comb begin
        state_d       = state_q;
        rdata         = 32'h0;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_wdata = 32'h0;
        mem_req_be    = 4'h0;
        wr_en         = 1'b0;
        wr_idx        = req_idx;
        wr_off        = req_off;
        wr_data       = req_wdata;
        wr_be         = req_be;
        tag_we        = 1'b0;
        miss_start    = 1'b0;
        load_hit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_we) begin
                    // Write-through: every store goes to memory; only hits update the line.
                    mem_req_valid = 1'b1;
                    mem_req_we    = 1'b1;
                    mem_req_addr  = {req_addr[31:2], 2'b00};
                    mem_req_wdata = req_wdata;
                    mem_req_be    = req_be;
                    stall         = ~mem_req_ready;
                    wr_en         = mem_req_ready && hit;
                end else if (req_valid) begin
                    if (hit) begin
                        rdata    = rd_word;
                        load_hit = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        miss_start = 1'b1;
                        state_d    = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {fill_line_q, (OFF_W+2)'(0)};
                if (mem_req_ready) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    wr_en   = 1'b1;
                    wr_idx  = fill_idx;
                    wr_off  = beat_q;
                    wr_data = mem_rdata;
                    wr_be   = 4'hF;
                    if (beat_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic post_fill_q;

    // Load lookup counters; the re-lookup right after a fill is not a new hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_fill_q <= 1'b0;
            hit_cnt     <= 32'h0;
            miss_cnt    <= 32'h0;
        end else begin
            post_fill_q <= tag_we;
            if (load_hit && !post_fill_q) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = load_hit;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// load/store/idle traffic against a behavioural cache + memory model.
module tb_dcache_ctrl;

    localparam int unsigned SETS = 64;
    localparam int unsigned LW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        inv = 1'b0;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_req_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .inv           (inv),
        .rdata         (rdata),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_req_ready (mem_req_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: backing memory keyed by word-aligned byte address,
    // and the cache contents per set.
    logic [31:0] mem [int unsigned];
    bit          mvalid [SETS];
    logic [31:0] mtag   [SETS];
    logic [31:0] mdata  [SETS][LW];

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 32'd16) % SETS);
    endfunction

    function automatic int off_of(input logic [31:0] a);
        return int'((a / 32'd4) % LW);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 32'd1024;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[set_of(a)] && (mtag[set_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
    endtask

    // One idle cycle, optionally asserting invalidate.
    task automatic do_idle(input bit inv_i);
        req_valid = 1'b0;
        inv = inv_i;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_memreq", 32'(mem_req_valid), 32'd0);
        step();
        if (inv_i) clear_model();
        inv = 1'b0;
    endtask

    // Store: request held until accepted; stall tracks ~ready.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int wait_n);
        logic [31:0] wa;
        wa = a & ~32'h3;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        for (int w = 0; w <= wait_n; w++) begin
            mem_req_ready = (w == wait_n);
            @(negedge clk);
            chk("st_stall", 32'(stall), (w == wait_n) ? 32'd0 : 32'd1);
            chk("st_valid", 32'(mem_req_valid), 32'd1);
            chk("st_we", 32'(mem_req_we), 32'd1);
            chk("st_addr", mem_req_addr, wa);
            chk("st_wdata", mem_req_wdata, d);
            chk("st_be", 32'(mem_req_be), 32'(be));
            step();
        end
        mem_req_ready = 1'b0;
        req_valid = 1'b0;
        mem[wa] = merge(mem_rd(wa), d, be);
        if (model_hit(a)) mdata[set_of(a)][off_of(a)] = merge(mdata[set_of(a)][off_of(a)], d, be);
    endtask

    // Load: checks every cycle until the hit cycle. inv_last asserts inv with the
    // final beat of the first fill; abort_beat>0 resets after that many beats.
    task automatic do_load(input logic [31:0] a, input bit inv_last, input int abort_beat,
                           output int nfills, output logic [31:0] got);
        logic [31:0] line;
        bit inv_now;
        int wait_n;
        int gaps;
        nfills = 0;
        got = 32'hX;
        line = a & ~32'hF;
        inv_now = inv_last;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; inv = 1'b0;
        forever begin
            @(negedge clk);
            if (model_hit(a)) begin
                chk("ld_hit_stall", 32'(stall), 32'd0);
                chk("ld_hit_rdata", rdata, mdata[set_of(a)][off_of(a)]);
                chk("ld_hit_memreq", 32'(mem_req_valid), 32'd0);
                got = rdata;
                step();
                break;
            end
            chk("ld_miss_stall", 32'(stall), 32'd1);
            chk("ld_miss_memreq", 32'(mem_req_valid), 32'd0);
            step();
            wait_n = $urandom_range(0, 2);
            for (int w = 0; w <= wait_n; w++) begin
                mem_req_ready = (w == wait_n);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                @(negedge clk);
                chk("fill_stall", 32'(stall), 32'd1);
                chk("fill_req_valid", 32'(mem_req_valid), 32'd1);
                chk("fill_req_we", 32'(mem_req_we), 32'd0);
                chk("fill_req_addr", mem_req_addr, line);
                step();
            end
            mem_req_ready = 1'b0;
            nfills++;
            for (int b = 0; b < int'(LW); b++) begin
                gaps = $urandom_range(0, 1);
                repeat (gaps) begin
                    mem_rvalid = 1'b0;
                    @(negedge clk);
                    chk("beat_gap_stall", 32'(stall), 32'd1);
                    chk("beat_gap_memreq", 32'(mem_req_valid), 32'd0);
                    step();
                end
                mem_rvalid = 1'b1;
                mem_rdata = mem_rd(line + 32'(4 * b));
                inv = inv_now && (b == int'(LW) - 1);
                @(negedge clk);
                chk("beat_stall", 32'(stall), 32'd1);
                step();
                if (abort_beat == b + 1) begin
                    mem_rvalid = 1'b0;
                    req_valid = 1'b0;
                    rst = 1'b1;
                    #1;
                    chk("rst_stall", 32'(stall), 32'd0);
                    chk("rst_memreq", 32'(mem_req_valid), 32'd0);
                    clear_model();
                    @(negedge clk);
                    rst = 1'b0;
                    step();
                    return;
                end
            end
            mem_rvalid = 1'b0;
            inv = 1'b0;
            if (inv_now) begin
                clear_model();
            end else begin
                mvalid[set_of(a)] = 1'b1;
                mtag[set_of(a)] = tag_of(a);
                for (int b = 0; b < int'(LW); b++) mdata[set_of(a)][b] = mem_rd(line + 32'(4 * b));
            end
            inv_now = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        logic [31:0] got;
        logic [31:0] a;
        int r;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_memreq", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        step();
        do_idle(1'b0);

        // Cold load, line returns 0xA0..0xA3.
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        do_load(32'h100, 1'b0, 0, nf, got);
        chk("t1_fills", 32'(nf), 32'd1);
        chk("t1_rdata", got, 32'hA0);

        do_load(32'h10C, 1'b0, 0, nf, got);
        chk("t2_fills", 32'(nf), 32'd0);
        chk("t2_rdata", got, 32'hA3);

        do_store(32'h104, 32'hDEAD_BEEF, 4'b0011, 2);
        do_load(32'h104, 1'b0, 0, nf, got);
        chk("t3_rdata", got, 32'h0000_BEEF);

        do_store(32'h2000, 32'h1234_5678, 4'hF, 0);
        do_load(32'h2000, 1'b0, 0, nf, got);
        chk("t4_fills", 32'(nf), 32'd1);
        chk("t4_rdata", got, 32'h1234_5678);

        do_load(32'h300, 1'b1, 0, nf, got);
        chk("t5_fills", 32'(nf), 32'd2);

        do_load(32'h400, 1'b0, 2, nf, got);
        // Stray beats after reset must be ignored in IDLE.
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        do_idle(1'b0);
        do_idle(1'b0);
        mem_rvalid = 1'b0;
        do_load(32'h400, 1'b0, 0, nf, got);
        chk("t6_fills", 32'(nf), 32'd1);
        chk("t6_rdata", got, mem_rd(32'h400));

        // Randomized traffic over a small set of colliding addresses.
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_load(a, ($urandom_range(0, 9) == 0), 0, nf, got);
            end else if (r < 7) begin
                do_store(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            end else begin
                do_idle($urandom_range(0, 7) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
